// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction memory loader: state encoding,
// memory geometry and frame-length decoding.
package instr_loader_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MEM_DEPTH = 256;

    localparam logic [7:0] DEFAULT_START_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } loader_state_e;

    // A length byte of zero encodes a full-memory (256-byte) frame.
    function automatic logic [8:0] frame_len(input logic [7:0] len);
        return (len == 8'd0) ? 9'(MEM_DEPTH) : {1'b0, len};
    endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Idle-cycle counter for the loader: counts enabled cycles since the last
// clear and flags the cycle on which the limit is reached.
module loader_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Expiry is a combinational flag so the owner can let a same-cycle
    // accepted byte take priority over it.
    assign expired = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Writer side of the 256 x 8 instruction memory: parses framed byte-stream
// images, writes payload bytes, verifies the checksum and holds the CPU.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 8'h00,
    parameter logic [7:0]        START_BYTE     = DEFAULT_START_BYTE,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [8:0]        bytes_written
);

    loader_state_e     state;
    loader_state_e     state_nxt;
    logic              accept;
    logic              timed;
    logic              expired;
    logic [8:0]        remaining;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        checksum;

    logic start_frame;
    logic len_load;
    logic data_write;
    logic frame_pass;
    logic frame_fail;

    assign in_ready = 1'b1;
    assign accept   = in_valid && in_ready;
    assign timed    = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);

    loader_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || !timed),
        .enable (timed),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && (in_data == START_BYTE)) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    state_nxt = S_DATA;
                end else if (expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (remaining == 9'd1) begin
                        state_nxt = S_CHK;
                    end
                end else if (expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_nxt = (in_data == checksum) ? S_DONE : S_ERR;
                end else if (expired) begin
                    state_nxt = S_ERR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_frame = 1'b0;
        len_load    = 1'b0;
        data_write  = 1'b0;
        frame_pass  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: start_frame = accept && (in_data == START_BYTE);
            S_LEN:                 len_load    = accept;
            S_DATA:                data_write  = accept;
            S_CHK:                 frame_pass  = accept && (in_data == checksum);
            default: ;
        endcase
        // Covers both checksum mismatch and timeout expiry.
        frame_fail = (state_nxt == S_ERR) && (state != S_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we        <= 1'b0;
            mem_addr      <= BASE_ADDR;
            mem_wdata     <= '0;
            cpu_hold      <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            bytes_written <= '0;
            remaining     <= '0;
            wr_addr       <= BASE_ADDR;
            checksum      <= '0;
        end else begin
            mem_we <= data_write;
            if (data_write) begin
                mem_addr      <= wr_addr;
                mem_wdata     <= in_data;
                wr_addr       <= wr_addr + 8'd1;
                checksum      <= checksum + in_data;
                bytes_written <= bytes_written + 9'd1;
                remaining     <= remaining - 9'd1;
            end
            if (len_load) begin
                remaining <= frame_len(in_data);
                wr_addr   <= BASE_ADDR;
            end
            if (start_frame) begin
                cpu_hold      <= 1'b1;
                load_done     <= 1'b0;
                load_error    <= 1'b0;
                bytes_written <= '0;
                checksum      <= '0;
            end
            if (frame_pass) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
            end
            if (frame_fail) begin
                load_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised self-checking bench for instr_mem_loader: two instances with
// different base addresses share one byte stream built frame by frame.
module tb_instr_mem_loader;

    localparam int unsigned TO    = 16;
    localparam logic [7:0]  BASE0 = 8'h00;
    localparam logic [7:0]  BASE1 = 8'hFE;
    localparam logic [7:0]  SB    = 8'hA5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [7:0]      in_data;
    logic [1:0]      in_ready;
    logic [1:0]      mem_we;
    logic [1:0][7:0] mem_addr;
    logic [1:0][7:0] mem_wdata;
    logic [1:0]      cpu_hold;
    logic [1:0]      load_done;
    logic [1:0]      load_error;
    logic [1:0][8:0] bytes_written;

    int checks = 0;
    int errors = 0;

    logic [7:0] payload[$];

    always #5 clk = ~clk;

    instr_mem_loader #(.BASE_ADDR(BASE0), .TIMEOUT_CYCLES(TO)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .cpu_hold(cpu_hold[0]), .load_done(load_done[0]),
        .load_error(load_error[0]), .bytes_written(bytes_written[0])
    );

    instr_mem_loader #(.BASE_ADDR(BASE1), .TIMEOUT_CYCLES(TO)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .cpu_hold(cpu_hold[1]), .load_done(load_done[1]),
        .load_error(load_error[1]), .bytes_written(bytes_written[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] base_of(input int i);
        return (i == 0) ? BASE0 : BASE1;
    endfunction

    function automatic logic [7:0] payload_sum();
        logic [7:0] s = 8'd0;
        foreach (payload[k]) s = s + payload[k];
        return s;
    endfunction

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == SB);
        return b;
    endfunction

    task automatic check_reset_values();
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_ready", in_ready[i], 1);
            check_eq("rst_we", mem_we[i], 0);
            check_eq("rst_addr", mem_addr[i], base_of(i));
            check_eq("rst_wdata", mem_wdata[i], 0);
            check_eq("rst_hold", cpu_hold[i], 0);
            check_eq("rst_done", load_done[i], 0);
            check_eq("rst_err", load_error[i], 0);
            check_eq("rst_bytes", bytes_written[i], 0);
        end
    endtask

    task automatic tick_idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_eq("we_idle", mem_we[i], 0);
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) tick_idle();
    endtask

    // One accepted byte; a data byte must appear on the write port right after.
    task automatic push(input logic [7:0] b, input bit is_data, input int idx);
        logic [7:0] ea;
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (is_data) begin
                ea = base_of(i) + 8'(idx);
                check_eq("we_data", mem_we[i], 1);
                check_eq("wr_addr", mem_addr[i], ea);
                check_eq("wr_data", mem_wdata[i], b);
            end else begin
                check_eq("we_ctrl", mem_we[i], 0);
            end
        end
    endtask

    function automatic int pick_gap(input int max_gap);
        if (max_gap == 0) return 0;
        if ($urandom_range(3) == 0) return max_gap;
        return int'($urandom_range(max_gap));
    endfunction

    task automatic send_frame(input logic [7:0] len_field, input logic [7:0] chk, input int max_gap);
        int         n;
        bit         good;
        logic [7:0] last_addr;
        n    = (len_field == 8'd0) ? 256 : int'(len_field);
        good = (chk == payload_sum());
        push(SB, 0, 0);
        gap(pick_gap(max_gap));
        for (int i = 0; i < 2; i++) begin
            check_eq("start_hold", cpu_hold[i], 1);
            check_eq("start_done", load_done[i], 0);
            check_eq("start_err", load_error[i], 0);
            check_eq("start_bytes", bytes_written[i], 0);
        end
        push(len_field, 0, 0);
        gap(pick_gap(max_gap));
        for (int k = 0; k < n; k++) begin
            push(payload[k], 1, k);
            gap(pick_gap(max_gap));
        end
        push(chk, 0, 0);
        for (int i = 0; i < 2; i++) begin
            last_addr = base_of(i) + 8'(n - 1);
            check_eq("end_done", load_done[i], good);
            check_eq("end_err", load_error[i], !good);
            check_eq("end_hold", cpu_hold[i], !good);
            check_eq("end_bytes", bytes_written[i], n);
            check_eq("end_addr", mem_addr[i], last_addr);
        end
    endtask

    task automatic fill_random(input int n);
        payload.delete();
        for (int k = 0; k < n; k++) payload.push_back(8'($urandom));
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;
        gap(2);

        payload = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h03, 8'h66, 0);
        gap(3);

        payload = '{8'h01, 8'h02};
        send_frame(8'h02, 8'h04, 2);
        gap(3);

        payload = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(8'h03, 8'h31, 1);

        push(8'h00, 0, 0);
        push(8'h5A, 0, 0);
        push(8'hFF, 0, 0);
        for (int i = 0; i < 2; i++) check_eq("junk_bytes", bytes_written[i], 3);
        payload = '{8'h7E};
        send_frame(8'h01, 8'h7E, 0);

        // Frame abandoned after one data byte: error after exactly TO idle cycles.
        push(SB, 0, 0);
        push(8'h04, 0, 0);
        push(8'h01, 1, 0);
        gap(TO - 1);
        for (int i = 0; i < 2; i++) begin
            check_eq("to_early_err", load_error[i], 0);
            check_eq("to_early_hold", cpu_hold[i], 1);
        end
        tick_idle();
        for (int i = 0; i < 2; i++) begin
            check_eq("to_err", load_error[i], 1);
            check_eq("to_done", load_done[i], 0);
            check_eq("to_hold", cpu_hold[i], 1);
            check_eq("to_bytes", bytes_written[i], 1);
        end
        gap(4);
        fill_random(5);
        send_frame(8'd5, payload_sum(), TO - 1);

        for (int f = 0; f < 8; f++) begin
            int         n;
            logic [7:0] chk;
            for (int j = 0; j < int'($urandom_range(3)); j++) push(junk_byte(), 0, 0);
            n = int'($urandom_range(48, 1));
            fill_random(n);
            chk = payload_sum();
            if ($urandom_range(1) == 0) chk = chk + 8'($urandom_range(255, 1));
            send_frame(8'(n), chk, TO - 1);
            gap(int'($urandom_range(3)));
        end

        // Reset in the middle of a full-memory frame, with a byte on the bus.
        fill_random(256);
        push(SB, 0, 0);
        push(8'h00, 0, 0);
        for (int k = 0; k < 100; k++) push(payload[k], 1, k);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = payload[100];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_reset_values();
        reset = 1'b0;
        gap(3);
        for (int i = 0; i < 2; i++) check_eq("post_rst_hold", cpu_hold[i], 0);

        fill_random(256);
        send_frame(8'h00, payload_sum(), 0);
        gap(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500us;
        errors++;
        $display("FAIL watchdog got=running exp=finished t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
